pmem_responder: RTL and testbench

PMEM_RESPONDER -- requirements
Module: pmem_responder

---
 rtl/pmem_responder.sv | 121 ++++++++++++
 tb/tb_pmem_responder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_responder.sv
// Line-wide memory responder with fixed access latency, periodic refresh and
// cyc/stb request handshake with retry while refresh is owed or in progress.
module pmem_responder #(
  parameter int DATA_W         = 256,
  parameter int ADDR_W         = 8,
  parameter int LATENCY        = 4,
  parameter int REFRESH_PERIOD = 64,
  parameter int REFRESH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_action_cyc,
  input  logic              mem_action_stb,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_resp,
  output logic              mem_retry
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, REFRESH} state_e;

  localparam int REF_W = 12;
  localparam int CNT_W = 4;
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_PERIOD - 1);
  localparam logic [CNT_W-1:0] ACC_LAST = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);
  localparam logic [CNT_W-1:0] RFS_LAST = CNT_W'(REFRESH_CYCLES - 1);

  state_e              state_q;
  logic [REF_W-1:0]    ref_cnt_q;
  logic                ref_pend_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                resp_q;
  logic [DATA_W-1:0]   mem_q [2**ADDR_W];

  logic                req;
  logic                ref_wrap;
  logic                accept;
  logic                go_resp;
  logic                op_write;
  logic [ADDR_W-1:0]   op_addr;
  logic [DATA_W-1:0]   op_wdata;

  // With LATENCY=1 the access completes straight out of IDLE, so the
  // operation fields come from the bus instead of the latches.
  always_comb begin
    req      = mem_action_cyc & mem_action_stb;
    ref_wrap = (ref_cnt_q == REF_LAST);
    accept   = (state_q == IDLE) && !ref_pend_q && req;
    go_resp  = (accept && (LATENCY == 1)) ||
               ((state_q == ACCESS) && mem_action_cyc && (cnt_q == ACC_LAST));
    op_write = (state_q == IDLE) ? mem_write   : wr_q;
    op_addr  = (state_q == IDLE) ? mem_address : addr_q;
    op_wdata = (state_q == IDLE) ? mem_wdata   : wdata_q;
  end

  // NOTE: retry is combinational so the initiator sees the refusal in the same
  // cycle it presents the request.
  assign mem_retry = req && ((state_q == REFRESH) || ((state_q == IDLE) && ref_pend_q));
  assign mem_resp  = resp_q;
  assign mem_rdata = rdata_q;

  // NOTE: storage sits in its own clocked block with no reset; resetting a
  // memory array forces it into flops and its contents must survive reset.
  always_ff @(posedge clk) begin
    if (go_resp && op_write) mem_q[op_addr] <= op_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ref_cnt_q  <= '0;
      ref_pend_q <= 1'b0;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      resp_q     <= 1'b0;
    end else begin
      ref_cnt_q <= ref_wrap ? '0 : ref_cnt_q + 1'b1;
      // A wrap always wins so a newly owed refresh is never lost.
      if (ref_wrap)                             ref_pend_q <= 1'b1;
      else if (state_q == IDLE && ref_pend_q)   ref_pend_q <= 1'b0;

      resp_q <= go_resp;
      if (go_resp && !op_write) rdata_q <= mem_q[op_addr];

      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (ref_pend_q) begin
            state_q <= REFRESH;
          end else if (req) begin
            wr_q    <= mem_write;
            addr_q  <= mem_address;
            wdata_q <= mem_wdata;
            state_q <= (LATENCY == 1) ? RESP : ACCESS;
          end
        end
        ACCESS: begin
          if (!mem_action_cyc)        state_q <= IDLE;
          else if (cnt_q == ACC_LAST) state_q <= RESP;
          else                        cnt_q   <= cnt_q + 1'b1;
        end
        RESP: state_q <= IDLE;
        REFRESH: begin
          if (cnt_q == RFS_LAST) state_q <= IDLE;
          else                   cnt_q   <= cnt_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_responder.sv
// Directed bench for pmem_responder: a cycle-level behavioural model checks all
// outputs every cycle; directed scenarios pin latency, refresh and abort timing.
module tb_pmem_responder;

  localparam int DW  = 256;
  localparam int AW  = 8;
  localparam int LAT = 4;
  localparam int RP  = 64;
  localparam int RC  = 2;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          cyc   = 1'b0;
  logic          stb   = 1'b0;
  logic          we    = 1'b0;
  logic [AW-1:0] addr  = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] mem_rdata;
  logic          mem_resp;
  logic          mem_retry;

  pmem_responder #(
    .DATA_W(DW), .ADDR_W(AW), .LATENCY(LAT),
    .REFRESH_PERIOD(RP), .REFRESH_CYCLES(RC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_action_cyc(cyc),
    .mem_action_stb(stb),
    .mem_write     (we),
    .mem_address   (addr),
    .mem_wdata     (wdata),
    .mem_rdata     (mem_rdata),
    .mem_resp      (mem_resp),
    .mem_retry     (mem_retry)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_n    = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc_n <= 0;
    else        cyc_n <= cyc_n + 1;
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: time since reset, owed refresh, remaining refresh
  // cycles and the cycle in which an in-flight access must respond.
  int            m_t;
  bit            m_pend, m_busy, m_in_resp;
  int            m_ref_left, m_resp_at;
  bit            l_we;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata, m_rdata;
  logic [DW-1:0] mem_m [256];

  task automatic model_do_op();
    m_in_resp = 1'b1;
    if (l_we) mem_m[l_addr] = l_wdata;
    else      m_rdata       = mem_m[l_addr];
  endtask

  always @(negedge clk) begin
    bit req, idle, wrap;
    if (!rst_n) begin
      m_t = 0; m_pend = 0; m_busy = 0; m_in_resp = 0;
      m_ref_left = 0; m_rdata = '0;
      check("rst_resp",  {255'd0, mem_resp},  '0);
      check("rst_retry", {255'd0, mem_retry}, '0);
      check("rst_rdata", mem_rdata,           '0);
    end else begin
      req  = cyc && stb;
      idle = !m_busy && !m_in_resp && (m_ref_left == 0);
      check("resp",  {255'd0, mem_resp},  {255'd0, m_in_resp});
      check("retry", {255'd0, mem_retry},
            {255'd0, req && ((m_ref_left > 0) || (idle && m_pend))});
      check("rdata", mem_rdata, m_rdata);
      wrap = ((m_t % RP) == RP - 1);
      if (m_in_resp) begin
        m_in_resp = 0;
      end else if (m_ref_left > 0) begin
        m_ref_left--;
      end else if (m_busy) begin
        if (!cyc) m_busy = 0;
        else if (m_t + 1 == m_resp_at) begin
          m_busy = 0;
          model_do_op();
        end
      end else if (m_pend) begin
        m_ref_left = RC;
        m_pend     = 0;
      end else if (req) begin
        l_we = we; l_addr = addr; l_wdata = wdata;
        m_resp_at = m_t + LAT;
        if (LAT == 1) model_do_op();
        else          m_busy = 1;
      end
      if (wrap) m_pend = 1;
      m_t++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_cycle(input int n);
    while (cyc_n < n) tick();
  endtask

  task automatic wait_resp(output int acc_c, output int resp_c, output int n_retry,
                           output logic [DW-1:0] rd);
    acc_c = -1; resp_c = -1; n_retry = 0; rd = '0;
    for (int i = 0; i < 40 && resp_c < 0; i++) begin
      @(negedge clk);
      if (mem_retry)      n_retry++;
      else if (acc_c < 0) acc_c = cyc_n;
      if (mem_resp) begin
        resp_c = cyc_n;
        rd     = mem_rdata;
      end
      tick();
    end
    check("resp_seen", {255'd0, resp_c >= 0}, 1);
  endtask

  task automatic access(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int acc_c, output int resp_c, output int n_retry,
                        output logic [DW-1:0] rd);
    cyc = 1; stb = 1; we = w; addr = a; wdata = d;
    wait_resp(acc_c, resp_c, n_retry, rd);
    cyc = 0; stb = 0;
  endtask

  localparam logic [DW-1:0] PAT_A5 = {32{8'hA5}};
  localparam logic [DW-1:0] PAT_3C = {32{8'h3C}};
  localparam logic [DW-1:0] PAT_D1 = {8{32'h1111_0001}};
  localparam logic [DW-1:0] PAT_D2 = {8{32'h2222_0002}};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, r, n, a2, r2;
    logic [DW-1:0] rd, rd2;
    int cnt;

    repeat (3) tick();
    rst_n = 1;

    // Write then read, first request on the first edge after reset.
    access(1, 8'h10, PAT_A5, a, r, n, rd);
    check("wr_acc_cycle", a, 0);
    check("wr_latency",   r - a, 4);
    access(0, 8'h10, '0, a, r, n, rd);
    check("rd_latency", r - a, 4);
    check("rd_data",    rd, PAT_A5);
    check("rd_retry",   n, 0);

    access(1, 8'h20, PAT_3C, a, r, n, rd);
    access(1, 8'h01, PAT_D1, a, r, n, rd);
    access(1, 8'h02, PAT_D2, a, r, n, rd);

    // Back-to-back reads with cyc&stb held through the first RESP.
    cyc = 1; stb = 1; we = 0; addr = 8'h01;
    wait_resp(a, r, n, rd);
    addr = 8'h02;
    wait_resp(a2, r2, n, rd2);
    cyc = 0; stb = 0;
    check("b2b_resp1", r, 29);
    check("b2b_resp2", r2, 34);
    check("b2b_acc2",  a2, r + 1);
    check("b2b_data1", rd, PAT_D1);
    check("b2b_data2", rd2, PAT_D2);

    // Abort: drop cyc two cycles after accepting a write.
    cyc = 1; stb = 1; we = 1; addr = 8'h20; wdata = '1;
    tick(); tick();
    cyc = 0; stb = 0;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (mem_resp) cnt++;
      tick();
    end
    check("abort_noresp", cnt, 0);
    access(0, 8'h20, '0, a, r, n, rd);
    check("abort_keep", rd, PAT_3C);

    // Refresh collision: ignored cyc-only cycles, then a request while refresh is owed.
    wait_cycle(60);
    cyc = 1; stb = 0; we = 0; addr = 8'h10;
    wait_cycle(64);
    access(0, 8'h10, '0, a, r, n, rd);
    check("coll_retries", n, 3);
    check("coll_acc",     a, 67);
    check("coll_resp",    r, 71);
    check("coll_data",    rd, PAT_A5);

    // Counter wrap during an access is deferred to the next IDLE.
    wait_cycle(126);
    access(0, 8'h01, '0, a, r, n, rd);
    check("wrap_acc",   a, 126);
    check("wrap_resp",  r, 130);
    check("wrap_retry", n, 0);
    access(0, 8'h02, '0, a, r, n, rd);
    check("post_ref_retries", n, 3);
    check("post_ref_acc",     a, 134);
    check("post_ref_resp",    r, 138);
    check("post_ref_data",    rd, PAT_D2);

    // Reset in the middle of a write access.
    cyc = 1; stb = 1; we = 1; addr = 8'h10; wdata = {32{8'h77}};
    tick(); tick();
    #3 rst_n = 0;
    #1;
    check("rst_async_resp",  {255'd0, mem_resp},  '0);
    check("rst_async_retry", {255'd0, mem_retry}, '0);
    check("rst_async_rdata", mem_rdata,           '0);
    cyc = 0; stb = 0;
    tick(); tick();
    rst_n = 1;
    access(0, 8'h10, '0, a, r, n, rd);
    check("post_rst_acc",  a, 0);
    check("post_rst_lat",  r - a, 4);
    check("post_rst_data", rd, PAT_A5);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
